// File: rtl/fire_squeeze_sequencer.sv
// Sequences the 1x1 squeeze engine through fire configs FIRST_FIRE..LAST_FIRE:
// per fire, load run length, stream data-valid, drain, check results, hand off bank.
module fire_squeeze_sequencer #(
    parameter int unsigned FIRST_FIRE = 0,
    parameter int unsigned LAST_FIRE  = 7,
    parameter int unsigned DRAIN_CYC  = 8,
    parameter int unsigned CW         = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sq_outvalid,
    input  logic       ds_ready,
    output logic [2:0] firesel,
    output logic       sq_data_valid,
    output logic       bank_sel,
    output logic       fire_done,
    output logic       all_done,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_HANDOFF
    } state_t;

    localparam logic [2:0]    FIRST_SEL = 3'(FIRST_FIRE);
    localparam logic [2:0]    LAST_SEL  = 3'(LAST_FIRE);
    localparam logic [CW-1:0] DRAIN_END = CW'(DRAIN_CYC - 1);

    state_t        r_state;
    logic [2:0]    r_firesel;
    logic          r_sq_data_valid;
    logic          r_bank_sel;
    logic          r_fire_done;
    logic          r_all_done;
    logic          r_busy;
    logic          r_err;
    logic [CW-1:0] r_run_len;
    logic [CW-1:0] r_exp_out;
    logic [CW-1:0] r_cyc_cnt;
    logic [CW-1:0] r_out_cnt;

    logic [9:0]    w_ic;
    logic [5:0]    w_s;
    logic [6:0]    w_f;
    logic [CW-1:0] w_exp_out;
    logic [CW-1:0] w_run_len;
    logic          w_count_en;
    logic [CW-1:0] w_out_cnt_nxt;

    always_comb begin
        w_ic = 10'd64;
        w_s  = 6'd55;
        w_f  = 7'd16;
        case (r_firesel)
            3'd0: begin w_ic = 10'd64;  w_s = 6'd55; w_f = 7'd16; end
            3'd1: begin w_ic = 10'd128; w_s = 6'd55; w_f = 7'd16; end
            3'd2: begin w_ic = 10'd128; w_s = 6'd27; w_f = 7'd32; end
            3'd3: begin w_ic = 10'd256; w_s = 6'd27; w_f = 7'd32; end
            3'd4: begin w_ic = 10'd256; w_s = 6'd13; w_f = 7'd48; end
            3'd5: begin w_ic = 10'd384; w_s = 6'd13; w_f = 7'd48; end
            3'd6: begin w_ic = 10'd384; w_s = 6'd13; w_f = 7'd64; end
            default: begin w_ic = 10'd512; w_s = 6'd13; w_f = 7'd64; end
        endcase
    end

    // IC/16 and F/8 are taken as bit slices; the table values are exact multiples.
    assign w_exp_out = CW'(w_s) * CW'(w_s) * CW'(w_f[6:3]);
    assign w_run_len = CW'(w_ic[9:4]) * w_exp_out;

    assign w_count_en    = sq_outvalid && ((r_state == S_RUN) || (r_state == S_DRAIN))
                           && (r_out_cnt != '1);
    assign w_out_cnt_nxt = w_count_en ? r_out_cnt + CW'(1) : r_out_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_firesel       <= FIRST_SEL;
            r_sq_data_valid <= 1'b0;
            r_bank_sel      <= 1'b0;
            r_fire_done     <= 1'b0;
            r_all_done      <= 1'b0;
            r_busy          <= 1'b0;
            r_err           <= 1'b0;
            r_run_len       <= '0;
            r_exp_out       <= '0;
            r_cyc_cnt       <= '0;
            r_out_cnt       <= '0;
        end else begin
            r_fire_done <= 1'b0;
            r_all_done  <= 1'b0;
            r_out_cnt   <= w_out_cnt_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_LOAD;
                        r_firesel <= FIRST_SEL;
                        r_busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_run_len       <= w_run_len;
                    r_exp_out       <= w_exp_out;
                    r_cyc_cnt       <= '0;
                    r_out_cnt       <= '0;
                    r_sq_data_valid <= 1'b1;
                    r_state         <= S_RUN;
                end
                S_RUN: begin
                    if (r_cyc_cnt == r_run_len - CW'(1)) begin
                        r_cyc_cnt       <= '0;
                        r_sq_data_valid <= 1'b0;
                        r_state         <= S_DRAIN;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_cyc_cnt == DRAIN_END) begin
                        // Include a result arriving on the final drain cycle in the check.
                        r_fire_done <= 1'b1;
                        r_err       <= r_err | (w_out_cnt_nxt != r_exp_out);
                        r_cyc_cnt   <= '0;
                        r_state     <= S_HANDOFF;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + CW'(1);
                    end
                end
                S_HANDOFF: begin
                    if (ds_ready) begin
                        r_bank_sel <= ~r_bank_sel;
                        if (r_firesel == LAST_SEL) begin
                            r_all_done <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_firesel <= r_firesel + 3'd1;
                            r_state   <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign firesel       = r_firesel;
    assign sq_data_valid = r_sq_data_valid;
    assign bank_sel      = r_bank_sel;
    assign fire_done     = r_fire_done;
    assign all_done      = r_all_done;
    assign busy          = r_busy;
    assign err           = r_err;

endmodule

// File: tb/tb_fire_squeeze_sequencer.sv
// Bench for fire_squeeze_sequencer: fires 4..5 with randomized result pulses,
// handoff stall, sticky error, ignored start/outvalid and mid-run reset.
module tb_fire_squeeze_sequencer;

    localparam int FF = 4;
    localparam int LF = 5;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       sq_outvalid = 1'b0;
    logic       ds_ready = 1'b1;
    logic [2:0] firesel;
    logic       sq_data_valid;
    logic       bank_sel;
    logic       fire_done;
    logic       all_done;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    bit err_model = 1'b0;

    int cfg_ic [8] = '{64, 128, 128, 256, 256, 384, 384, 512};
    int cfg_s  [8] = '{55, 55, 27, 27, 13, 13, 13, 13};
    int cfg_f  [8] = '{16, 16, 32, 32, 48, 48, 64, 64};

    fire_squeeze_sequencer #(
        .FIRST_FIRE(FF),
        .LAST_FIRE (LF),
        .DRAIN_CYC (DC),
        .CW        (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sq_outvalid  (sq_outvalid),
        .ds_ready     (ds_ready),
        .firesel      (firesel),
        .sq_data_valid(sq_data_valid),
        .bank_sel     (bank_sel),
        .fire_done    (fire_done),
        .all_done     (all_done),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic int model_exp(input int fire);
        return cfg_s[fire] * cfg_s[fire] * (cfg_f[fire] / 8);
    endfunction

    function automatic int model_run(input int fire);
        return (cfg_ic[fire] / 16) * model_exp(fire);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (firesel !== 3'(FF) || sq_data_valid !== 1'b0 || bank_sel !== 1'b0 ||
            fire_done !== 1'b0 || all_done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got fs=%0d v=%b b=%b fd=%b ad=%b busy=%b err=%b, expected fs=%0d and all zero",
                     firesel, sq_data_valid, bank_sel, fire_done, all_done, busy, err, FF);
        end
        rst = 1'b1;
    endtask

    // Entered at the negedge of the LOAD cycle; leaves at the negedge after HANDOFF exit.
    task automatic run_fire(input int fire, input int short_by, input int hold, input bit is_last);
        int L = model_run(fire);
        int E = model_exp(fire);
        int rem = E - short_by;
        int vcount = 0, vbad = 0, other_bad = 0, stall_bad = 0;
        bit bank0;

        n_checks++;
        if (busy !== 1'b1 || firesel !== 3'(fire) || sq_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_state_f%0d: got busy=%b fs=%0d v=%b, expected busy=1 fs=%0d v=0",
                     fire, busy, firesel, sq_data_valid, fire);
        end
        bank0 = bank_sel;
        sq_outvalid = 1'b1;  // pulse during LOAD must not be counted

        for (int k = 0; k < L + DC; k++) begin
            @(negedge clk);
            if (sq_data_valid === 1'b1) vcount++;
            if (sq_data_valid !== (k < L)) vbad++;
            if (firesel !== 3'(fire) || busy !== 1'b1 || fire_done !== 1'b0 ||
                all_done !== 1'b0 || bank_sel !== bank0) other_bad++;
            sq_outvalid = ($urandom_range(L + DC - k - 1, 0) < rem);
            if (sq_outvalid) rem--;
            start = (k == L / 2);
        end
        @(negedge clk);
        start = 1'b0;
        if (short_by != 0) err_model = 1'b1;

        n_checks++;
        if (vcount != L) begin
            n_fail++;
            $display("FAIL run_len_f%0d: got %0d valid cycles, expected %0d", fire, vcount, L);
        end
        n_checks++;
        if (vbad != 0) begin
            n_fail++;
            $display("FAIL valid_shape_f%0d: got %0d misplaced cycles, expected 0", fire, vbad);
        end
        n_checks++;
        if (other_bad != 0) begin
            n_fail++;
            $display("FAIL run_stable_f%0d: got %0d bad cycles, expected 0", fire, other_bad);
        end
        n_checks++;
        if (fire_done !== 1'b1 || err !== err_model || sq_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fire_done_f%0d: got fd=%b err=%b v=%b, expected fd=1 err=%b v=0",
                     fire, fire_done, err, sq_data_valid, err_model);
        end

        sq_outvalid = 1'($urandom_range(1, 0));
        ds_ready = (hold == 0);
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || firesel !== 3'(fire) || bank_sel !== bank0 ||
                sq_data_valid !== 1'b0 || fire_done !== 1'b0) stall_bad++;
            sq_outvalid = 1'($urandom_range(1, 0));
            if (i == hold) ds_ready = 1'b1;
        end
        if (hold > 0) begin
            n_checks++;
            if (stall_bad != 0) begin
                n_fail++;
                $display("FAIL handoff_stall_f%0d: got %0d bad cycles, expected 0", fire, stall_bad);
            end
        end

        @(negedge clk);
        sq_outvalid = 1'b0;
        n_checks++;
        if (bank_sel !== ~bank0 || all_done !== is_last || busy !== ~is_last) begin
            n_fail++;
            $display("FAIL handoff_exit_f%0d: got bank=%b ad=%b busy=%b, expected bank=%b ad=%b busy=%b",
                     fire, bank_sel, all_done, busy, ~bank0, is_last, ~is_last);
        end
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sq_outvalid = 1'($urandom_range(1, 0));
        end
        n_checks++;
        if (busy !== 1'b0 || sq_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: got busy=%b v=%b, expected 0 0", busy, sq_data_valid);
        end
        sq_outvalid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_fire(4, 0, 100, 1'b0);
        run_fire(5, 1, 0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (all_done !== 1'b0 || busy !== 1'b0 || bank_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL after_all_done: got ad=%b busy=%b bank=%b, expected 0 0 0",
                     all_done, busy, bank_sel);
        end
    endtask

    task automatic test_sticky_abort();
        int vbad = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (err !== 1'b1 || firesel !== 3'(FF) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b fs=%0d busy=%b, expected err=1 fs=%0d busy=1",
                     err, firesel, busy, FF);
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sq_data_valid !== 1'b1 || firesel !== 3'(FF) || err !== 1'b1) vbad++;
            start = (k == 20);
        end
        start = 1'b0;
        n_checks++;
        if (vbad != 0) begin
            n_fail++;
            $display("FAIL start_in_run: got %0d bad cycles, expected 0", vbad);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        err_model = 1'b0;
        n_checks++;
        if (firesel !== 3'(FF) || sq_data_valid !== 1'b0 || bank_sel !== 1'b0 ||
            fire_done !== 1'b0 || all_done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: got fs=%0d v=%b b=%b fd=%b ad=%b busy=%b err=%b, expected fs=%0d and all zero",
                     firesel, sq_data_valid, bank_sel, fire_done, all_done, busy, err, FF);
        end
    endtask

    task automatic test_restart();
        int vbad = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || sq_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_abort: got busy=%b v=%b, expected 0 0", busy, sq_data_valid);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (firesel !== 3'(FF) || busy !== 1'b1 || err !== 1'b0 || sq_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_load: got fs=%0d busy=%b err=%b v=%b, expected fs=%0d busy=1 err=0 v=0",
                     firesel, busy, err, sq_data_valid, FF);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sq_data_valid !== 1'b1) vbad++;
        end
        n_checks++;
        if (vbad != 0) begin
            n_fail++;
            $display("FAIL restart_run: got %0d low-valid cycles, expected 0", vbad);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_sticky_abort();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
